// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants for the ID/EX operand stage.
package cpu_pkg;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] rn_data;
    logic [REG_W-1:0]  rd;
    logic              is_load;
    logic              writes_rd;
  } ex_bundle_t;

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} hz_state_t;

  // XZR reads as zero even if a forwarded value claims that index.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [REG_W-1:0]  idx,
    input logic              fwd_valid,
    input logic [DATA_W-1:0] fwd_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (idx == XZR) return '0;
    if (fwd_valid)  return fwd_data;
    return rf_data;
  endfunction
endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side, forwarding and EX-side signals around the operand stage.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
);
  logic              id_valid;
  logic [REG_W-1:0]  id_rm;
  logic [REG_W-1:0]  id_rn;
  logic [REG_W-1:0]  id_rd;
  logic              id_is_load;
  logic              id_writes_rd;
  logic [DATA_W-1:0] rf_rm_data;
  logic [DATA_W-1:0] rf_rn_data;
  logic [REG_W-1:0]  fwd_rm_lookup;
  logic [REG_W-1:0]  fwd_rn_lookup;
  logic [DATA_W-1:0] fwd_rm_data;
  logic              fwd_rm_valid;
  logic [DATA_W-1:0] fwd_rn_data;
  logic              fwd_rn_valid;
  logic              flush;
  logic              stall_ifid;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rm_data;
  logic [DATA_W-1:0] ex_rn_data;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_is_load;
  logic              ex_writes_rd;

  modport master (
    output id_valid, id_rm, id_rn, id_rd, id_is_load, id_writes_rd,
           rf_rm_data, rf_rn_data, fwd_rm_data, fwd_rm_valid,
           fwd_rn_data, fwd_rn_valid, flush,
    input  fwd_rm_lookup, fwd_rn_lookup, stall_ifid, ex_valid,
           ex_rm_data, ex_rn_data, ex_rd, ex_is_load, ex_writes_rd
  );

  modport slave (
    input  id_valid, id_rm, id_rn, id_rd, id_is_load, id_writes_rd,
           rf_rm_data, rf_rn_data, fwd_rm_data, fwd_rm_valid,
           fwd_rn_data, fwd_rn_valid, flush,
    output fwd_rm_lookup, fwd_rn_lookup, stall_ifid, ex_valid,
           ex_rm_data, ex_rn_data, ex_rd, ex_is_load, ex_writes_rd
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load and the ID sources.
module load_use_detect #(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_writes_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rn,
  output logic             hazard
);
  import cpu_pkg::*;

  // Loads into XZR discard their result, so nothing can depend on them.
  assign hazard = ex_valid & ex_is_load & ex_writes_rd & (ex_rd != REG_W'(XZR)) &
                  id_valid & ((id_rm == ex_rd) | (id_rn == ex_rd));
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX operand register with forwarding merge and load-use bubble insertion.
// Optional HAZARD_STATS_EN adds saturating bubble/flush counters.
module id_ex_operand_stage #(
  parameter int DATA_W           = cpu_pkg::DATA_W,
  parameter int REG_W            = cpu_pkg::REG_W,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  id_ex_operand_stage_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stat_bubbles,
  output logic [15:0]           stat_flushes
`endif
);
  import cpu_pkg::*;

  localparam logic [0:0] ST_RUN   = 1'(RUN);
  localparam logic [0:0] ST_STALL = 1'(STALL);

  logic [0:0]        state;
  logic [1:0]        cnt;
  ex_bundle_t        ex_p1;
  logic              hazard;
  logic [DATA_W-1:0] rm_sel_p0;
  logic [DATA_W-1:0] rn_sel_p0;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_valid     (ex_p1.valid),
    .ex_is_load   (ex_p1.is_load),
    .ex_writes_rd (ex_p1.writes_rd),
    .ex_rd        (ex_p1.rd),
    .id_valid     (bus.id_valid),
    .id_rm        (bus.id_rm),
    .id_rn        (bus.id_rn),
    .hazard       (hazard)
  );

  assign bus.fwd_rm_lookup = bus.id_rm;
  assign bus.fwd_rn_lookup = bus.id_rn;

  assign rm_sel_p0 = select_operand(bus.id_rm, bus.fwd_rm_valid, bus.fwd_rm_data, bus.rf_rm_data);
  assign rn_sel_p0 = select_operand(bus.id_rn, bus.fwd_rn_valid, bus.fwd_rn_data, bus.rf_rn_data);

  // A flush kills the held instruction, so IF/ID must not be held that cycle.
  assign bus.stall_ifid = ~bus.flush & ((state == ST_STALL) | hazard);

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_p1 <= '0;
      state <= ST_RUN;
      cnt   <= '0;
    end else if (bus.flush) begin
      ex_p1.valid <= 1'b0;
      state       <= ST_RUN;
      cnt         <= '0;
    end else if (state == ST_STALL) begin
      ex_p1.valid <= 1'b0;
      cnt         <= cnt - 2'd1;
      if (cnt <= 2'd1) state <= ST_RUN;
    end else if (hazard) begin
      ex_p1.valid <= 1'b0;
      cnt         <= 2'(LOAD_USE_BUBBLES - 1);
      if (LOAD_USE_BUBBLES > 1) state <= ST_STALL;
    end else begin
      ex_p1.valid <= bus.id_valid;
      // Payload only moves with a real instruction so it stays 0 after reset.
      if (bus.id_valid) begin
        ex_p1.rm_data   <= rm_sel_p0;
        ex_p1.rn_data   <= rn_sel_p0;
        ex_p1.rd        <= bus.id_rd;
        ex_p1.is_load   <= bus.id_is_load;
        ex_p1.writes_rd <= bus.id_writes_rd;
      end
    end
  end

  assign bus.ex_valid     = ex_p1.valid;
  assign bus.ex_rm_data   = ex_p1.rm_data;
  assign bus.ex_rn_data   = ex_p1.rn_data;
  assign bus.ex_rd        = ex_p1.rd;
  assign bus.ex_is_load   = ex_p1.is_load;
  assign bus.ex_writes_rd = ex_p1.writes_rd;

`ifdef HAZARD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  // Every stall cycle inserts exactly one bubble into EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_bubbles <= '0;
      stat_flushes <= '0;
    end else begin
      if (bus.stall_ifid) stat_bubbles <= sat_inc(stat_bubbles, 32'hFFFF_FFFF);
      if (bus.flush)      stat_flushes <= 16'(sat_inc({16'd0, stat_flushes}, 32'h0000_FFFF));
    end
  end
`endif
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: one instance with 1 bubble, one with 2 bubbles,
// both driven identically and checked against a behavioural model each cycle.
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        id_valid, id_is_load, id_writes_rd, flush;
  logic [4:0]  id_rm, id_rn, id_rd;
  logic [63:0] rf_rm_data, rf_rn_data, fwd_rm_data, fwd_rn_data;
  logic        fwd_rm_valid, fwd_rn_valid;

  logic        o_stall [2], o_valid [2], o_ld [2], o_wr [2];
  logic [63:0] o_rm [2], o_rn [2];
  logic [4:0]  o_rd [2], o_lrm [2], o_lrn [2];
`ifdef HAZARD_STATS_EN
  logic [31:0] o_sb [2];
  logic [15:0] o_sf [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_operand_stage_if bus ();
    assign bus.id_valid     = id_valid;
    assign bus.id_rm        = id_rm;
    assign bus.id_rn        = id_rn;
    assign bus.id_rd        = id_rd;
    assign bus.id_is_load   = id_is_load;
    assign bus.id_writes_rd = id_writes_rd;
    assign bus.rf_rm_data   = rf_rm_data;
    assign bus.rf_rn_data   = rf_rn_data;
    assign bus.fwd_rm_data  = fwd_rm_data;
    assign bus.fwd_rm_valid = fwd_rm_valid;
    assign bus.fwd_rn_data  = fwd_rn_data;
    assign bus.fwd_rn_valid = fwd_rn_valid;
    assign bus.flush        = flush;
    assign o_stall[g] = bus.stall_ifid;
    assign o_valid[g] = bus.ex_valid;
    assign o_rm[g]    = bus.ex_rm_data;
    assign o_rn[g]    = bus.ex_rn_data;
    assign o_rd[g]    = bus.ex_rd;
    assign o_ld[g]    = bus.ex_is_load;
    assign o_wr[g]    = bus.ex_writes_rd;
    assign o_lrm[g]   = bus.fwd_rm_lookup;
    assign o_lrn[g]   = bus.fwd_rn_lookup;

    id_ex_operand_stage #(.LOAD_USE_BUBBLES(g + 1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef HAZARD_STATS_EN
      ,
      .stat_bubbles (o_sb[g]),
      .stat_flushes (o_sf[g])
`endif
    );
  end

  // Behavioural model: what EX holds and how many bubbles are still owed.
  int          bubbles_cfg [2] = '{1, 2};
  logic        m_valid [2], m_ld [2], m_wr [2];
  logic [63:0] m_rm [2], m_rn [2];
  logic [4:0]  m_rd [2];
  int          m_left [2];
  longint      m_bub [2], m_fl [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] opsel(input logic [4:0] idx, input logic fv,
                                        input logic [63:0] fd, input logic [63:0] rd);
    if (idx == 5'd31) return 64'd0;
    return fv ? fd : rd;
  endfunction

  function automatic bit model_hazard(input int i);
    return m_valid[i] && m_ld[i] && m_wr[i] && m_rd[i] != 5'd31 && id_valid &&
           (id_rm == m_rd[i] || id_rn == m_rd[i]);
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lookup_rm[%0d]", i), o_lrm[i], id_rm);
      chk($sformatf("lookup_rn[%0d]", i), o_lrn[i], id_rn);
      if (!reset)
        chk($sformatf("stall[%0d]", i), o_stall[i],
            !flush && (m_left[i] > 0 || model_hazard(i)));
      chk($sformatf("ex_valid[%0d]", i), o_valid[i], m_valid[i]);
      if (m_valid[i]) begin
        chk($sformatf("ex_rm[%0d]", i), o_rm[i], m_rm[i]);
        chk($sformatf("ex_rn[%0d]", i), o_rn[i], m_rn[i]);
        chk($sformatf("ex_rd[%0d]", i), o_rd[i], m_rd[i]);
        chk($sformatf("ex_ld[%0d]", i), o_ld[i], m_ld[i]);
        chk($sformatf("ex_wr[%0d]", i), o_wr[i], m_wr[i]);
      end
`ifdef HAZARD_STATS_EN
      chk($sformatf("stat_bub[%0d]", i), o_sb[i], m_bub[i]);
      chk($sformatf("stat_fl[%0d]", i), o_sf[i], m_fl[i]);
`endif
    end
  endtask

  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      bit hz;
      hz = model_hazard(i);
      if (reset) begin
        m_valid[i] = 0; m_rm[i] = 0; m_rn[i] = 0; m_rd[i] = 0; m_ld[i] = 0; m_wr[i] = 0;
        m_left[i] = 0; m_bub[i] = 0; m_fl[i] = 0;
      end else if (flush) begin
        m_valid[i] = 0; m_left[i] = 0;
        if (m_fl[i] < 65535) m_fl[i]++;
      end else if (m_left[i] > 0) begin
        m_valid[i] = 0; m_left[i]--; m_bub[i]++;
      end else if (hz) begin
        m_valid[i] = 0; m_left[i] = bubbles_cfg[i] - 1; m_bub[i]++;
      end else begin
        m_valid[i] = id_valid;
        if (id_valid) begin
          m_rm[i] = opsel(id_rm, fwd_rm_valid, fwd_rm_data, rf_rm_data);
          m_rn[i] = opsel(id_rn, fwd_rn_valid, fwd_rn_data, rf_rn_data);
          m_rd[i] = id_rd; m_ld[i] = id_is_load; m_wr[i] = id_writes_rd;
        end
      end
    end
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    #1;
    compare_all();
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rm = 0; id_rn = 0; id_rd = 0; id_is_load = 0; id_writes_rd = 0;
    rf_rm_data = 0; rf_rn_data = 0; fwd_rm_data = 0; fwd_rn_data = 0;
    fwd_rm_valid = 0; fwd_rn_valid = 0; flush = 0;
  endtask

  task automatic instr(input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd,
                       input logic ld);
    id_valid = 1; id_rm = rm; id_rn = rn; id_rd = rd; id_is_load = ld; id_writes_rd = 1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_rm[i] = 0; m_rn[i] = 0; m_rd[i] = 0; m_ld[i] = 0; m_wr[i] = 0;
      m_left[i] = 0; m_bub[i] = 0; m_fl[i] = 0;
    end
    idle();
    reset = 1;
    @(negedge clk);
    step(); step();
    reset = 0;
    #1;
    chk("rst_valid", o_valid[0], 0);
    chk("rst_rm", o_rm[1], 0);
    chk("rst_rd", o_rd[0], 0);
    chk("rst_stall", o_stall[1], 0);

    // ADD x1 = x2 + x3 from the register file
    instr(5'd2, 5'd3, 5'd1, 0); rf_rm_data = 64'd5; rf_rn_data = 64'd7;
    step();
    chk("add_rm", o_rm[0], 64'd5);
    chk("add_rn", o_rn[0], 64'd7);
    chk("add_valid", o_valid[0], 1);

    instr(5'd4, 5'd3, 5'd1, 0); fwd_rm_valid = 1; fwd_rm_data = 64'hAA; rf_rm_data = 64'h11;
    step();
    chk("fwd_rm", o_rm[0], 64'hAA);

    instr(5'd31, 5'd3, 5'd1, 0); fwd_rm_data = 64'hFF;
    step();
    chk("xzr_rm", o_rm[0], 64'd0);
    fwd_rm_valid = 0;

    // LDUR x9 followed by a reader of x9
    instr(5'd1, 5'd2, 5'd9, 1);
    step();
    instr(5'd9, 5'd9, 5'd10, 0); rf_rm_data = 64'h33; rf_rn_data = 64'h44;
    #1;
    chk("lu_stall_a", o_stall[0], 1);
    step();
    chk("lu_bubble_a", o_valid[0], 0);
    chk("lu_nostall_a", o_stall[0], 0);
    chk("lu_stall_b", o_stall[1], 1);
    step();
    chk("lu_issue_a", o_valid[0], 1);
    chk("lu_issue_rm_a", o_rm[0], 64'h33);
    chk("lu_bubble2_b", o_valid[1], 0);
    step();
    chk("lu_issue_b", o_valid[1], 1);
    chk("lu_issue_rn_b", o_rn[1], 64'h44);

    // Flush in the hazard cycle of the 2-bubble instance
    instr(5'd1, 5'd2, 5'd9, 1);
    step();
    instr(5'd9, 5'd1, 5'd10, 0); flush = 1;
    #1;
    chk("fl_stall_b", o_stall[1], 0);
    step();
    chk("fl_valid_b", o_valid[1], 0);
    flush = 0; instr(5'd5, 5'd6, 5'd7, 0);
    #1;
    chk("fl_run_b", o_stall[1], 0);
    step();
    chk("fl_issue_b", o_valid[1], 1);

    // Reset while the 2-bubble instance is stalled
    instr(5'd1, 5'd2, 5'd9, 1);
    step();
    instr(5'd9, 5'd1, 5'd10, 0);
    step();
    chk("rs_in_stall_b", o_stall[1], 1);
    reset = 1;
    step();
    reset = 0; idle();
    #1;
    chk("rs_stall_b", o_stall[1], 0);
    chk("rs_valid_b", o_valid[1], 0);
    chk("rs_rm_b", o_rm[1], 0);
    chk("rs_rd_b", o_rd[1], 0);
    chk("rs_ld_b", o_ld[1], 0);
`ifdef HAZARD_STATS_EN
    chk("rs_stat_bub_b", o_sb[1], 0);
    chk("rs_stat_fl_b", o_sf[1], 0);
`endif

    // Random traffic over a small register set so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 15) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 4); id_rm = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); id_rn = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); id_rd = (r == 4) ? 5'd31 : 5'(r);
      id_is_load   = 1'($urandom_range(0, 1));
      id_writes_rd = ($urandom_range(0, 3) != 0);
      rf_rm_data  = {$urandom, $urandom};
      rf_rn_data  = {$urandom, $urandom};
      fwd_rm_data = {$urandom, $urandom};
      fwd_rn_data = {$urandom, $urandom};
      fwd_rm_valid = 1'($urandom_range(0, 1));
      fwd_rn_valid = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
